// File: rtl/cpu_seq_if.sv
// ============================================================================
// Module      : cpu_seq_if
// Description : Memory bus between the cpu_seq sequencer and its memory.
// Revision    : 1.0
// ============================================================================
`default_nettype none

interface cpu_seq_if #(
    parameter int DW = 8,
    parameter int AW = 8
);
    logic [AW-1:0] mem_addr;
    logic          mem_rden;
    logic          mem_wren;
    logic [DW-1:0] mem_wdata;
    logic          mem_ready;
    logic [DW-1:0] mem_rdata;

    modport master (
        output mem_addr, mem_rden, mem_wren, mem_wdata,
        input  mem_ready, mem_rdata
    );

    modport slave (
        input  mem_addr, mem_rden, mem_wren, mem_wdata,
        output mem_ready, mem_rdata
    );
endinterface

`default_nettype wire

// File: rtl/cpu_seq.sv
// ============================================================================
// Module      : cpu_seq
// Description : Fetch / execute-A / execute-B sequencer with LD/ST decode.
//               Optional macro CPU_SEQ_JUMP_EN enables the JMP opcode.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module cpu_seq #(
    parameter int DW = 8,
    parameter int AW = 8,
    parameter int FW = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic             halt,
    cpu_seq_if.master        mem,
    input  logic [DW-1:0]    st_data,
    output logic [DW-1:0]    ld_data,
    output logic             ld_valid,
    output logic [AW-1:0]    pc,
    output logic [FW*DW-1:0] ir,
    output logic [3:0]       stage
);

    localparam int KW = (FW > 1) ? $clog2(FW) : 1;

    typedef enum logic [1:0] {
        S_WAIT  = 2'd0,
        S_FETCH = 2'd1,
        S_EXECA = 2'd2,
        S_EXECB = 2'd3
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [KW-1:0] k;
    logic          halt_req;
    logic [DW-1:0] wdata;
    logic [AW-1:0] addr;
    logic          rden;
    logic          wren;
    logic          last_word;
    logic          done;
    logic [AW-1:0] operand;
    logic [2:0]    op_hi;
    logic [1:0]    op_mid;
    logic          is_ld;
    logic          is_st;

    assign op_hi  = ir[FW*DW-1 -: 3];
    assign op_mid = ir[FW*DW-4 -: 2];
    assign is_ld  = (op_hi == 3'b000) && (op_mid == 2'b01);
    assign is_st  = (op_hi == 3'b000) && (op_mid == 2'b10);

    generate
        if (FW > 1) begin : g_operand
            assign operand = ir[(FW-2)*DW +: AW];
        end else begin : g_no_operand
            assign operand = '0;
        end
    endgenerate

    assign last_word     = (k == KW'(FW-1));
    assign stage         = 4'b0001 << state;
    assign mem.mem_addr  = addr;
    assign mem.mem_rden  = rden;
    assign mem.mem_wren  = wren;
    assign mem.mem_wdata = wdata;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_WAIT;
        end else begin
            state <= state_nxt;
        end
    end

    // Bus controls are decoded from registered state only, so a stall holds them steady.
    always_comb begin
        state_nxt = state;
        rden      = 1'b0;
        wren      = 1'b0;
        addr      = '0;
        done      = 1'b0;
        case (state)
            S_WAIT: begin
                if (run && !halt) state_nxt = S_FETCH;
            end
            S_FETCH: begin
                rden = 1'b1;
                addr = pc;
                if (mem.mem_ready && last_word) state_nxt = S_EXECA;
            end
            S_EXECA: begin
                state_nxt = S_EXECB;
            end
            S_EXECB: begin
                if (is_ld) begin
                    rden = 1'b1;
                    addr = operand;
                    done = mem.mem_ready;
                end else if (is_st) begin
                    wren = 1'b1;
                    addr = operand;
                    done = mem.mem_ready;
                end else begin
                    done = 1'b1;
                end
                if (done) state_nxt = (halt_req || halt) ? S_WAIT : S_FETCH;
            end
            default: state_nxt = S_WAIT;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc       <= '0;
            ir       <= '0;
            k        <= '0;
            halt_req <= 1'b0;
            wdata    <= '0;
            ld_data  <= '0;
            ld_valid <= 1'b0;
        end else begin
            ld_valid <= 1'b0;
            if (halt && (state != S_WAIT)) halt_req <= 1'b1;
            case (state)
                S_FETCH: begin
                    if (mem.mem_ready) begin
                        ir[(FW-1-int'(k))*DW +: DW] <= mem.mem_rdata;
                        pc <= pc + 1'b1;
                        k  <= last_word ? '0 : k + 1'b1;
                    end
                end
                S_EXECA: begin
                    wdata <= st_data;
                end
                S_EXECB: begin
                    if (done) begin
                        // Clearing here overrides a halt seen in this same cycle.
                        if (state_nxt == S_WAIT) halt_req <= 1'b0;
                        if (is_ld) begin
                            ld_data  <= mem.mem_rdata;
                            ld_valid <= 1'b1;
                        end
`ifdef CPU_SEQ_JUMP_EN
                        if (op_hi == 3'b001) pc <= operand;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_cpu_seq.sv
// ============================================================================
// Module      : tb_cpu_seq
// Description : Directed vector bench for cpu_seq (FW=2 main, FW=3 wrap instance).
// Revision    : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_cpu_seq;

    logic        clk = 1'b0;
    logic        rst, run, halt, ready;
    logic [7:0]  st_data;
    logic [7:0]  ld_data;
    logic        ld_valid;
    logic [7:0]  pc;
    logic [15:0] ir;
    logic [3:0]  stage;
    logic [7:0]  imem [256];

    logic [7:0]  wr_addr = 8'h00;
    logic [7:0]  wr_data = 8'h00;
    int          wr_cnt  = 0;

    logic        rst3, run3;
    logic [7:0]  ld3, pc3;
    logic        ldv3;
    logic [23:0] ir3;
    logic [3:0]  stage3;

    int vec_cnt = 0;
    int err_cnt = 0;

    always #5 clk = ~clk;

    cpu_seq_if #(.DW(8), .AW(8)) bus ();
    cpu_seq_if #(.DW(8), .AW(8)) bus3 ();

    assign bus.mem_ready  = ready;
    assign bus.mem_rdata  = imem[bus.mem_addr];
    assign bus3.mem_ready = 1'b1;
    assign bus3.mem_rdata = 8'h00;

    cpu_seq #(.DW(8), .AW(8), .FW(2)) dut (
        .clk(clk), .rst(rst), .run(run), .halt(halt), .mem(bus),
        .st_data(st_data), .ld_data(ld_data), .ld_valid(ld_valid),
        .pc(pc), .ir(ir), .stage(stage)
    );

    cpu_seq #(.DW(8), .AW(8), .FW(3)) dut3 (
        .clk(clk), .rst(rst3), .run(run3), .halt(1'b0), .mem(bus3),
        .st_data(8'h00), .ld_data(ld3), .ld_valid(ldv3),
        .pc(pc3), .ir(ir3), .stage(stage3)
    );

    always @(posedge clk) begin
        if (bus.mem_wren && bus.mem_ready) begin
            wr_addr <= bus.mem_addr;
            wr_data <= bus.mem_wdata;
            wr_cnt  <= wr_cnt + 1;
        end
    end

    typedef struct {
        logic [7:0] op;
        logic [7:0] opnd;
        logic [7:0] sd;
        logic [7:0] mval;
        logic       rd;
        logic       wr;
        logic       jmp;
    } vec_t;

    vec_t       vt [7];
    logic [7:0] pcm;

    function automatic vec_t mk(input logic [7:0] op, opnd, sd, mval,
                                input logic rd, wr, jmp);
        vec_t v;
        v.op = op; v.opnd = opnd; v.sd = sd; v.mval = mval;
        v.rd = rd; v.wr = wr; v.jmp = jmp;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Entered with the DUT in the first FETCH cycle at pc == pcm.
    task automatic run_instr(input vec_t v);
        logic [7:0] a1;
        a1 = pcm + 8'd1;
        imem[pcm] = v.op;
        imem[a1]  = v.opnd;
        if (v.rd) imem[v.opnd] = v.mval;
        st_data = v.sd;
        check("f0_stage", stage, 4'b0010);
        check("f0_rden", bus.mem_rden, 1'b1);
        check("f0_addr", bus.mem_addr, pcm);
        tick();
        check("f1_stage", stage, 4'b0010);
        check("f1_addr", bus.mem_addr, a1);
        check("ldv_low", ld_valid, 1'b0);
        tick();
        check("ea_stage", stage, 4'b0100);
        check("ea_pc", pc, pcm + 8'd2);
        check("ea_ir", ir, {v.op, v.opnd});
        check("ea_en", {bus.mem_rden, bus.mem_wren}, 2'b00);
        tick();
        check("eb_stage", stage, 4'b1000);
        check("eb_rden", bus.mem_rden, v.rd);
        check("eb_wren", bus.mem_wren, v.wr);
        if (v.rd || v.wr) check("eb_addr", bus.mem_addr, v.opnd);
        if (v.wr) check("eb_wdata", bus.mem_wdata, v.sd);
        tick();
        check("nx_stage", stage, 4'b0010);
        check("nx_ldv", ld_valid, v.rd);
        if (v.rd) check("nx_ld_data", ld_data, v.mval);
        if (v.wr) begin
            check("nx_wr_addr", wr_addr, v.opnd);
            check("nx_wr_data", wr_data, v.sd);
        end
        pcm = v.jmp ? v.opnd : pcm + 8'd2;
        check("nx_pc", pc, pcm);
    endtask

    initial begin
        logic jt;
        int   wc0;
        logic found;
`ifdef CPU_SEQ_JUMP_EN
        jt = 1'b1;
`else
        jt = 1'b0;
`endif
        vt[0] = mk(8'h08, 8'h40, 8'h00, 8'hA5, 1'b1, 1'b0, 1'b0);
        vt[1] = mk(8'h10, 8'h33, 8'h5C, 8'h00, 1'b0, 1'b1, 1'b0);
        vt[2] = mk(8'h00, 8'h12, 8'h11, 8'h00, 1'b0, 1'b0, 1'b0);
        vt[3] = mk(8'h18, 8'h50, 8'h22, 8'h00, 1'b0, 1'b0, 1'b0);
        vt[4] = mk(8'h48, 8'h40, 8'h33, 8'h00, 1'b0, 1'b0, 1'b0);
        vt[5] = mk(8'h0F, 8'h70, 8'h44, 8'h3C, 1'b1, 1'b0, 1'b0);
        vt[6] = mk(8'h20, 8'h80, 8'h55, 8'h00, 1'b0, 1'b0, jt);

        for (int i = 0; i < 256; i++) imem[i] = 8'h00;
        rst = 1'b0; rst3 = 1'b0; run = 1'b0; run3 = 1'b0;
        halt = 1'b0; ready = 1'b1; st_data = 8'h00;

        // Reset and idle behaviour
        tick(); tick();
        check("rst_stage", stage, 4'b0001);
        check("rst_pc", pc, 8'h00);
        check("rst_ir", ir, 16'h0000);
        check("rst_rden", bus.mem_rden, 1'b0);
        rst = 1'b1; rst3 = 1'b1;
        tick(); tick();
        check("idle_stage", stage, 4'b0001);
        run = 1'b1; halt = 1'b1;
        tick(); tick();
        check("run_halt_wait", stage, 4'b0001);
        halt = 1'b0;
        pcm = 8'h00;
        imem[0] = vt[0].op;
        imem[1] = vt[0].opnd;
        imem[8'h40] = vt[0].mval;
        tick();

        for (int i = 0; i < 7; i++) run_instr(vt[i]);

        // ST with fetch stall, then store held 4 cycles by mem_ready=0
        imem[pcm] = 8'h10;
        imem[pcm + 8'd1] = 8'h33;
        st_data = 8'h77;
        ready = 1'b0;
        tick(); tick();
        check("fstall_stage", stage, 4'b0010);
        check("fstall_pc", pc, pcm);
        check("fstall_addr", bus.mem_addr, pcm);
        check("fstall_rden", bus.mem_rden, 1'b1);
        ready = 1'b1;
        tick(); tick();
        check("st_ea_pc", pc, pcm + 8'd2);
        tick();
        ready = 1'b0;
        st_data = 8'hEE;
        wc0 = wr_cnt;
        for (int i = 0; i < 4; i++) begin
            check("st_stall_stage", stage, 4'b1000);
            check("st_stall_wren", bus.mem_wren, 1'b1);
            check("st_stall_rden", bus.mem_rden, 1'b0);
            check("st_stall_addr", bus.mem_addr, 8'h33);
            check("st_stall_wdata", bus.mem_wdata, 8'h77);
            if (i == 3) ready = 1'b1;
            tick();
        end
        check("st_done_stage", stage, 4'b0010);
        check("st_wr_cnt", wr_cnt, wc0 + 1);
        check("st_wr_data", wr_data, 8'h77);
        pcm = pcm + 8'd2;

        // One-cycle halt pulse during fetch: finish instruction, then WAIT
        imem[pcm] = 8'h00;
        imem[pcm + 8'd1] = 8'h00;
        halt = 1'b1;
        tick();
        halt = 1'b0;
        check("hp_f1_stage", stage, 4'b0010);
        tick();
        check("hp_ea_stage", stage, 4'b0100);
        tick();
        check("hp_eb_stage", stage, 4'b1000);
        run = 1'b0;
        tick();
        check("hp_wait_stage", stage, 4'b0001);
        run = 1'b1; halt = 1'b1;
        tick(); tick();
        check("hp_runhalt_stage", stage, 4'b0001);
        halt = 1'b0;
        pcm = pcm + 8'd2;
        tick();
        check("hp_resume_stage", stage, 4'b0010);
        check("hp_resume_pc", pc, pcm);

        // Asynchronous reset in the middle of an EXECB load access
        imem[pcm] = 8'h08;
        imem[pcm + 8'd1] = 8'h40;
        tick(); tick(); tick();
        ready = 1'b0;
        check("mr_eb_rden", bus.mem_rden, 1'b1);
        #2 rst = 1'b0;
        #1;
        check("mr_stage", stage, 4'b0001);
        check("mr_pc", pc, 8'h00);
        check("mr_ir", ir, 16'h0000);
        check("mr_rden", bus.mem_rden, 1'b0);
        check("mr_wren", bus.mem_wren, 1'b0);
        check("mr_addr", bus.mem_addr, 8'h00);
        check("mr_wdata", bus.mem_wdata, 8'h00);
        check("mr_ld_data", ld_data, 8'h00);
        check("mr_ld_valid", ld_valid, 1'b0);
        run = 1'b0; ready = 1'b1;
        tick();
        rst = 1'b1;
        tick();
        check("mr_after_stage", stage, 4'b0001);

        // FW=3 instance: pc wraps 0xFF -> 0x00 -> 0x01 inside one fetch
        run3 = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 3000 && !found; i++) begin
            tick();
            if (stage3 == 4'b0010 && pc3 == 8'hFF) found = 1'b1;
        end
        check("wrap_found", found, 1'b1);
        if (found) begin
            check("wrap_addr_ff", bus3.mem_addr, 8'hFF);
            tick();
            check("wrap_addr_00", bus3.mem_addr, 8'h00);
            check("wrap_pc_00", pc3, 8'h00);
            tick();
            check("wrap_addr_01", bus3.mem_addr, 8'h01);
            tick();
            check("wrap_ea_stage", stage3, 4'b0100);
            check("wrap_ea_pc", pc3, 8'h02);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

`default_nettype wire
